id_operand_pipe: RTL and testbench
==================================

Name: id_operand_pipe

Overview:
- Parametrised operand-fetch and ID/EX pipeline-register block for the MIPS16-style 5-stage core.
- Resolves each source operand from: the register file, an immediate, or the youngest matching forwarding source.
- Detects load-use hazards and requests a one-cycle stall.
- Resolves ID-stage branches using forwarded operands and tracks the delay slot.
- Sits between the decoder and EX; drives the ID/EX register directly.

Parameters:
- DATA_W, 16, operand/data width.
- RADDR_W, 4, register address width (GPRs plus SP/IH/T/RA).
- NRD, 2, number of source-operand read ports.
- NFWD, 2, number of forwarding sources; index 0 is the youngest (EX), NFWD-1 the oldest (MEM).
- CTRL_W, 8, width of opaque decoded control passed to EX (alusel/aluop).
- PC_W, 16, instruction address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high.
- id_valid_i  in  1  decoder presents an instruction.
- id_pc_i  in  PC_W  PC of ID instruction.
- rd_re_i  in  NRD  per-port read enable (0 = use immediate).
- rd_addr_i  in  NRD*RADDR_W  per-port register address.
- rf_data_i  in  NRD*DATA_W  register-file read data.
- imm_i  in  NRD*DATA_W  per-port immediate, already extended.
- fwd_we_i  in  NFWD  forwarding source writes a register.
- fwd_load_i  in  NFWD  source is a load whose data is not yet valid.
- fwd_waddr_i  in  NFWD*RADDR_W  forwarding destination address.
- fwd_wdata_i  in  NFWD*DATA_W  forwarding data.
- id_we_i  in  1  ID instruction writes a register.
- id_waddr_i  in  RADDR_W  ID destination.
- id_ctrl_i  in  CTRL_W  decoded control.
- br_type_i  in  2  branch type: NONE=0, ALWAYS=1, EQZ=2, NEZ=3; condition tested on port 0.
- br_target_i  in  PC_W  branch target from decoder.
- stall_i  in  1  global hold from controller.
- flush_i  in  1  kill ID instruction (exception/redirect).
- ex_valid_o  out  1  EX bundle valid.
- ex_op_o  out  NRD*DATA_W  resolved operands.
- ex_ctrl_o  out  CTRL_W.
- ex_we_o  out  1.
- ex_waddr_o  out  RADDR_W.
- ex_pc_o  out  PC_W.
- ex_in_delay_o  out  1  EX instruction occupies a branch delay slot.
- stall_req_o  out  1  load-use stall request (combinational).
- branch_flag_o  out  1  taken branch (combinational).
- branch_addr_o  out  PC_W  redirect target (combinational).
- stall_cnt_o  out  16  saturating count of load-use stall cycles.

Behaviour:
- Reset:
  - All registered outputs are 0: ex_valid_o, ex_op_o, ex_ctrl_o, ex_we_o, ex_waddr_o, ex_pc_o, ex_in_delay_o, stall_cnt_o.
  - The delay_pending flag is 0.
  - Reset overrides stall_i and flush_i.
  - Reset mid-stall drops the held bundle.
- Operand resolution, combinational, per port p:
  - If rd_re_i[p]=0, select imm_i[p].
  - Otherwise, search k=0..NFWD-1 for the first k with fwd_we_i[k] and fwd_waddr_i[k]==rd_addr_i[p].
  - If a match exists, select fwd_wdata_i[k]; if none, select rf_data_i[p].
  - No hardwired-zero register; address 0 forwards like any other.
- Load-use hazard:
  - hz[p] = rd_re_i[p] and the first matching k has fwd_load_i[k]=1.
  - An older non-load match does not mask a younger load match.
  - A younger non-load match masks an older load match.
  - stall_req_o = id_valid_i & ~flush_i & OR(hz).
- Branch:
  - taken = id_valid_i & ~stall_req_o & ~flush_i & (br_type==ALWAYS | (EQZ & op0==0) | (NEZ & op0!=0)).
  - branch_flag_o = taken; branch_addr_o = taken ? br_target_i : 0.
  - The comparison uses the forwarded op0.
- Register update at each clk edge, in priority order:
  1. rst: reset values.
  2. stall_i: hold all registers and delay_pending. stall_cnt_o does not count.
  3. flush_i: bubble (valid/we/ctrl/ops=0); clear delay_pending.
  4. stall_req_o: bubble; delay_pending holds; stall_cnt_o increments, saturating at 0xFFFF.
  5. id_valid_i: load the bundle.
     - ex_in_delay_o = delay_pending.
     - delay_pending = taken.
  6. Otherwise: bubble; delay_pending holds.
- Latency: one cycle from ID acceptance to EX visibility.
- A taken branch in a delay slot sets delay_pending again; the newer branch wins.

Decomposition:
- Shared package (defines include): BR_NONE/ALWAYS/EQZ/NEZ encodings, default widths, bubble control value (EXE_OP_NOP / EXE_SEL_SPECIAL as zero).
- Sub-module: operand_fwd_mux, one instance per port.
  - Inputs: re, addr, rf_data, imm and the forwarding buses.
  - Outputs: operand and hz. This is the priority search.

Test Plan:
- Forward priority:
  - Stimulus: port0 reads r3; EX writes r3=0x1111; MEM writes r3=0x2222.
  - Response: next cycle ex_op_o[0]=0x1111.
  - With EX we=0: ex_op_o[0]=0x2222.
  - With neither: rf value.
- Load-use:
  - Stimulus: EX is a load to r5; ID reads r5 on port1.
  - Response: stall_req_o=1, EX gets a bubble, stall_cnt_o=1.
  - Next cycle, the load moves to MEM with data 0xBEEF: ex_op_o[1]=0xBEEF, valid=1.
- Masked load:
  - Stimulus: MEM load r2; EX ALU writes r2=0x0042.
  - Response: no stall; operand=0x0042.
- BEQZ with forwarding:
  - Stimulus: op0 forwarded 0, target 0x0040.
  - Response: branch_flag_o=1, branch_addr_o=0x0040.
  - The next accepted instruction has ex_in_delay_o=1; the one after has 0.
  - Repeat with op0=1: no branch.
- stall_i and flush_i:
  - Stimulus: hold stall_i 3 cycles.
  - Response: EX outputs frozen; stall_cnt_o unchanged.
  - Stimulus: flush_i with a pending delay slot.
  - Response: bubble; ex_in_delay_o of the next instruction is 0.
- Reset: assert rst during a stall with valid EX bundle → all outputs 0 next cycle; stall_cnt_o=0.

Source files
------------

// File: rtl/id_operand_pipe_pkg.sv
// Shared encodings and default widths for the ID operand/forwarding stage.
// Imported by the interface, the forwarding mux and the top.
package id_operand_pipe_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RADDR_W_DEF = 4;
  localparam int NRD_DEF     = 2;
  localparam int NFWD_DEF    = 2;
  localparam int CTRL_W_DEF  = 8;
  localparam int PC_W_DEF    = 16;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_ALWAYS = 2'd1,
    BR_EQZ    = 2'd2,
    BR_NEZ    = 2'd3
  } br_type_e;

  // Bubble control: NOP op with the special selector, both zero.
  localparam logic [4:0] EXE_OP_NOP      = 5'd0;
  localparam logic [2:0] EXE_SEL_SPECIAL = 3'd0;
  localparam logic [7:0] CTRL_BUBBLE     = {EXE_SEL_SPECIAL, EXE_OP_NOP};

endpackage

// File: rtl/id_operand_pipe_if.sv
// Decoder-to-ID bundle and ID/EX register outputs.
// master: decoder/consumer side, slave: id_operand_pipe.
interface id_operand_pipe_if
  import id_operand_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int PC_W    = PC_W_DEF
);
  logic                      id_valid_i;
  logic [PC_W-1:0]           id_pc_i;
  logic [NRD-1:0]            rd_re_i;
  logic [NRD*RADDR_W-1:0]    rd_addr_i;
  logic [NRD*DATA_W-1:0]     rf_data_i;
  logic [NRD*DATA_W-1:0]     imm_i;
  logic                      id_we_i;
  logic [RADDR_W-1:0]        id_waddr_i;
  logic [CTRL_W-1:0]         id_ctrl_i;
  logic [1:0]                br_type_i;
  logic [PC_W-1:0]           br_target_i;

  logic                      ex_valid_o;
  logic [NRD*DATA_W-1:0]     ex_op_o;
  logic [CTRL_W-1:0]         ex_ctrl_o;
  logic                      ex_we_o;
  logic [RADDR_W-1:0]        ex_waddr_o;
  logic [PC_W-1:0]           ex_pc_o;
  logic                      ex_in_delay_o;

  modport master (
    output id_valid_i, id_pc_i, rd_re_i, rd_addr_i,
    output rf_data_i, imm_i, id_we_i, id_waddr_i,
    output id_ctrl_i, br_type_i, br_target_i,
    input  ex_valid_o, ex_op_o, ex_ctrl_o, ex_we_o,
    input  ex_waddr_o, ex_pc_o, ex_in_delay_o
  );

  modport slave (
    input  id_valid_i, id_pc_i, rd_re_i, rd_addr_i,
    input  rf_data_i, imm_i, id_we_i, id_waddr_i,
    input  id_ctrl_i, br_type_i, br_target_i,
    output ex_valid_o, ex_op_o, ex_ctrl_o, ex_we_o,
    output ex_waddr_o, ex_pc_o, ex_in_delay_o
  );
endinterface

// File: rtl/id_operand_pipe_operand_fwd_mux.sv
// One source operand: immediate, youngest forwarding match, or RF.
// Ports: re/addr/rf_data/imm, fwd_* buses in; op_o and hz_o out.
module operand_fwd_mux
  import id_operand_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NFWD    = NFWD_DEF
) (
  input  logic                     re_i,
  input  logic [RADDR_W-1:0]       addr_i,
  input  logic [DATA_W-1:0]        rf_data_i,
  input  logic [DATA_W-1:0]        imm_i,
  input  logic [NFWD-1:0]          fwd_we_i,
  input  logic [NFWD-1:0]          fwd_load_i,
  input  logic [NFWD*RADDR_W-1:0]  fwd_waddr_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata_i,
  output logic [DATA_W-1:0]        op_o,
  output logic                     hz_o
);
  // Walk oldest to youngest so the youngest match is applied last.
  always_comb begin
    op_o = rf_data_i;
    hz_o = 1'b0;
    if (!re_i) begin
      op_o = imm_i;
    end else begin
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_we_i[k] &&
            fwd_waddr_i[k*RADDR_W +: RADDR_W] == addr_i) begin
          op_o = fwd_wdata_i[k*DATA_W +: DATA_W];
          hz_o = fwd_load_i[k];
        end
      end
    end
  end
endmodule

// File: rtl/id_operand_pipe.sv
// Operand fetch, load-use detect, ID branch resolve and ID/EX register.
// Ports: clk/rst, id (slave bundle), fwd_* buses, stall/flush, status.
module id_operand_pipe
  import id_operand_pipe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int NFWD    = NFWD_DEF,
  parameter int CTRL_W  = CTRL_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  id_operand_pipe_if.slave         id,
  input  logic [NFWD-1:0]          fwd_we_i,
  input  logic [NFWD-1:0]          fwd_load_i,
  input  logic [NFWD*RADDR_W-1:0]  fwd_waddr_i,
  input  logic [NFWD*DATA_W-1:0]   fwd_wdata_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic                     stall_req_o,
  output logic                     branch_flag_o,
  output logic [PC_W-1:0]          branch_addr_o,
  output logic [15:0]              stall_cnt_o
);
  logic [NRD*DATA_W-1:0] op_d;
  logic [NRD-1:0]        hz;
  logic                  cond;
  logic                  taken;

  logic                  valid_q;
  logic [NRD*DATA_W-1:0] op_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic                  we_q;
  logic [RADDR_W-1:0]    waddr_q;
  logic [PC_W-1:0]       pc_q;
  logic                  in_dly_q;
  logic                  dly_pend_q;
  logic [15:0]           cnt_q;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    operand_fwd_mux #(
      .DATA_W (DATA_W),
      .RADDR_W(RADDR_W),
      .NFWD   (NFWD)
    ) u_mux (
      .re_i       (id.rd_re_i[p]),
      .addr_i     (id.rd_addr_i[p*RADDR_W +: RADDR_W]),
      .rf_data_i  (id.rf_data_i[p*DATA_W +: DATA_W]),
      .imm_i      (id.imm_i[p*DATA_W +: DATA_W]),
      .fwd_we_i   (fwd_we_i),
      .fwd_load_i (fwd_load_i),
      .fwd_waddr_i(fwd_waddr_i),
      .fwd_wdata_i(fwd_wdata_i),
      .op_o       (op_d[p*DATA_W +: DATA_W]),
      .hz_o       (hz[p])
    );
  end

  assign stall_req_o = id.id_valid_i & ~flush_i & (|hz);

  always_comb begin
    cond = 1'b0;
    unique case (1'b1)
      id.br_type_i == BR_ALWAYS: cond = 1'b1;
      id.br_type_i == BR_EQZ:    cond = op_d[DATA_W-1:0] == '0;
      id.br_type_i == BR_NEZ:    cond = op_d[DATA_W-1:0] != '0;
      default:                   cond = 1'b0;
    endcase
  end

  assign taken = id.id_valid_i & ~stall_req_o & ~flush_i & cond;
  assign branch_flag_o = taken;
  assign branch_addr_o = taken ? id.br_target_i : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      ctrl_q     <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      pc_q       <= '0;
      in_dly_q   <= 1'b0;
      dly_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else if (stall_i) begin
      // hold everything
    end else if (id.id_valid_i && !flush_i && !stall_req_o) begin
      valid_q    <= 1'b1;
      op_q       <= op_d;
      ctrl_q     <= id.id_ctrl_i;
      we_q       <= id.id_we_i;
      waddr_q    <= id.id_waddr_i;
      pc_q       <= id.id_pc_i;
      in_dly_q   <= dly_pend_q;
      dly_pend_q <= taken;
    end else begin
      valid_q  <= 1'b0;
      op_q     <= '0;
      ctrl_q   <= CTRL_W'(CTRL_BUBBLE);
      we_q     <= 1'b0;
      in_dly_q <= 1'b0;
      if (flush_i)
        dly_pend_q <= 1'b0;
      else if (stall_req_o && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
    end
  end

  assign id.ex_valid_o    = valid_q;
  assign id.ex_op_o       = op_q;
  assign id.ex_ctrl_o     = ctrl_q;
  assign id.ex_we_o       = we_q;
  assign id.ex_waddr_o    = waddr_q;
  assign id.ex_pc_o       = pc_q;
  assign id.ex_in_delay_o = in_dly_q;
  assign stall_cnt_o      = cnt_q;
endmodule

// File: tb/tb_id_operand_pipe.sv
// Directed bench for id_operand_pipe: forwarding, load-use, branch,
// stall/flush and reset behaviour with hand-computed expectations.
module tb_id_operand_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  fwd_we;
  logic [1:0]  fwd_load;
  logic [7:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        stall;
  logic        flush;
  logic        stall_req;
  logic        br_flag;
  logic [15:0] br_addr;
  logic [15:0] scnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_operand_pipe_if bus ();

  id_operand_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .id           (bus.slave),
    .fwd_we_i     (fwd_we),
    .fwd_load_i   (fwd_load),
    .fwd_waddr_i  (fwd_waddr),
    .fwd_wdata_i  (fwd_wdata),
    .stall_i      (stall),
    .flush_i      (flush),
    .stall_req_o  (stall_req),
    .branch_flag_o(br_flag),
    .branch_addr_o(br_addr),
    .stall_cnt_o  (scnt)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(int p, logic re, logic [3:0] a,
                        logic [15:0] rf, logic [15:0] imm);
    bus.rd_re_i[p]           = re;
    bus.rd_addr_i[p*4 +: 4]  = a;
    bus.rf_data_i[p*16 +: 16] = rf;
    bus.imm_i[p*16 +: 16]    = imm;
  endtask

  task automatic set_fwd(int k, logic we, logic ld, logic [3:0] a,
                         logic [15:0] d);
    fwd_we[k]            = we;
    fwd_load[k]          = ld;
    fwd_waddr[k*4 +: 4]  = a;
    fwd_wdata[k*16 +: 16] = d;
  endtask

  task automatic instr(logic [15:0] pc, logic [1:0] bt, logic [15:0] tgt);
    bus.id_valid_i  = 1'b1;
    bus.id_pc_i     = pc;
    bus.br_type_i   = bt;
    bus.br_target_i = tgt;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    fwd_we = '0; fwd_load = '0; fwd_waddr = '0; fwd_wdata = '0;
    bus.id_valid_i = 1'b0;
    bus.id_pc_i = '0;
    bus.rd_re_i = '0;
    bus.rd_addr_i = '0;
    bus.rf_data_i = '0;
    bus.imm_i = '0;
    bus.id_we_i = 1'b0;
    bus.id_waddr_i = '0;
    bus.id_ctrl_i = '0;
    bus.br_type_i = 2'd0;
    bus.br_target_i = '0;
    tick(); tick();
    chk("rst_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("rst_op", bus.ex_op_o, 32'd0);
    chk("rst_cnt", 32'(scnt), 32'd0);
    rst = 1'b0;

    // forward priority: EX beats MEM beats RF; port1 uses immediate
    instr(16'h0010, 2'd0, 16'h0);
    bus.id_we_i = 1'b1; bus.id_waddr_i = 4'd7; bus.id_ctrl_i = 8'h5A;
    set_rd(0, 1'b1, 4'd3, 16'h0AAA, 16'h0);
    set_rd(1, 1'b0, 4'd3, 16'h0BBB, 16'h0033);
    set_fwd(0, 1'b1, 1'b0, 4'd3, 16'h1111);
    set_fwd(1, 1'b1, 1'b0, 4'd3, 16'h2222);
    tick();
    chk("fwd_ex_op0", 32'(bus.ex_op_o[15:0]), 32'h1111);
    chk("imm_op1", 32'(bus.ex_op_o[31:16]), 32'h0033);
    chk("fwd_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("fwd_ctrl", 32'(bus.ex_ctrl_o), 32'h5A);
    chk("fwd_pc", 32'(bus.ex_pc_o), 32'h0010);
    chk("fwd_waddr", {27'd0, bus.ex_we_o, bus.ex_waddr_o}, 32'h17);
    fwd_we[0] = 1'b0;
    tick();
    chk("fwd_mem_op0", 32'(bus.ex_op_o[15:0]), 32'h2222);
    fwd_we = 2'b00;
    tick();
    chk("fwd_rf_op0", 32'(bus.ex_op_o[15:0]), 32'h0AAA);

    // load-use: EX load r5, ID reads r5 on port1
    set_rd(0, 1'b0, 4'd0, 16'h0, 16'h0001);
    set_rd(1, 1'b1, 4'd5, 16'h0CCC, 16'h0);
    set_fwd(0, 1'b1, 1'b1, 4'd5, 16'hDEAD);
    set_fwd(1, 1'b0, 1'b0, 4'd0, 16'h0);
    settle();
    chk("lu_stall_req", 32'(stall_req), 32'd1);
    tick();
    chk("lu_bubble", 32'(bus.ex_valid_o), 32'd0);
    chk("lu_cnt", 32'(scnt), 32'd1);
    set_fwd(0, 1'b0, 1'b0, 4'd0, 16'h0);
    set_fwd(1, 1'b1, 1'b0, 4'd5, 16'hBEEF);
    settle();
    chk("lu_release", 32'(stall_req), 32'd0);
    tick();
    chk("lu_op1", 32'(bus.ex_op_o[31:16]), 32'hBEEF);
    chk("lu_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("lu_cnt_hold", 32'(scnt), 32'd1);

    // masked load: MEM load r2, EX ALU r2
    set_rd(0, 1'b1, 4'd2, 16'h0, 16'h0);
    set_rd(1, 1'b0, 4'd0, 16'h0, 16'h0);
    set_fwd(0, 1'b1, 1'b0, 4'd2, 16'h0042);
    set_fwd(1, 1'b1, 1'b1, 4'd2, 16'h9999);
    settle();
    chk("mask_no_stall", 32'(stall_req), 32'd0);
    fwd_load = 2'b11;
    settle();
    chk("young_load_stall", 32'(stall_req), 32'd1);
    fwd_load = 2'b01;
    settle();
    chk("old_alu_nomask", 32'(stall_req), 32'd1);
    flush = 1'b1;
    settle();
    chk("flush_no_stall", 32'(stall_req), 32'd0);
    flush = 1'b0;
    fwd_load = 2'b10;
    tick();
    chk("mask_op0", 32'(bus.ex_op_o[15:0]), 32'h0042);

    // BEQZ on forwarded zero
    instr(16'h0020, 2'd2, 16'h0040);
    set_rd(0, 1'b1, 4'd4, 16'h0005, 16'h0);
    set_fwd(0, 1'b1, 1'b0, 4'd4, 16'h0000);
    set_fwd(1, 1'b0, 1'b0, 4'd0, 16'h0);
    settle();
    chk("beqz_flag", 32'(br_flag), 32'd1);
    chk("beqz_addr", 32'(br_addr), 32'h0040);
    tick();
    chk("beqz_not_dly", 32'(bus.ex_in_delay_o), 32'd0);
    instr(16'h0022, 2'd0, 16'h0);
    tick();
    chk("slot_dly", 32'(bus.ex_in_delay_o), 32'd1);
    instr(16'h0040, 2'd0, 16'h0);
    tick();
    chk("after_slot", 32'(bus.ex_in_delay_o), 32'd0);

    // BEQZ on forwarded one: not taken
    instr(16'h0042, 2'd2, 16'h0080);
    fwd_wdata[15:0] = 16'h0001;
    settle();
    chk("beqz1_flag", 32'(br_flag), 32'd0);
    chk("beqz1_addr", 32'(br_addr), 32'h0);
    tick();
    instr(16'h0044, 2'd0, 16'h0);
    tick();
    chk("beqz1_no_dly", 32'(bus.ex_in_delay_o), 32'd0);

    // BNEZ from RF, then stall_i holds the EX bundle
    instr(16'h0046, 2'd3, 16'h0100);
    fwd_we = 2'b00;
    set_rd(0, 1'b1, 4'd6, 16'h0007, 16'h0);
    settle();
    chk("bnez_flag", 32'(br_flag), 32'd1);
    tick();
    instr(16'h0099, 2'd0, 16'h0);
    stall = 1'b1;
    tick(); tick(); tick();
    chk("stall_pc", 32'(bus.ex_pc_o), 32'h0046);
    chk("stall_op0", 32'(bus.ex_op_o[15:0]), 32'h0007);
    chk("stall_valid", 32'(bus.ex_valid_o), 32'd1);
    chk("stall_cnt", 32'(scnt), 32'd1);

    // flush with pending delay slot clears it
    stall = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_bubble", 32'(bus.ex_valid_o), 32'd0);
    flush = 1'b0;
    instr(16'h0100, 2'd0, 16'h0);
    tick();
    chk("flush_dly", 32'(bus.ex_in_delay_o), 32'd0);
    chk("flush_next_pc", 32'(bus.ex_pc_o), 32'h0100);

    // reset during a stall with a valid bundle and a pending slot
    instr(16'h0200, 2'd1, 16'h0300);
    tick();
    stall = 1'b1;
    rst = 1'b1;
    tick();
    chk("rst2_valid", 32'(bus.ex_valid_o), 32'd0);
    chk("rst2_op", bus.ex_op_o, 32'd0);
    chk("rst2_pc", 32'(bus.ex_pc_o), 32'd0);
    chk("rst2_cnt", 32'(scnt), 32'd0);
    rst = 1'b0;
    stall = 1'b0;
    instr(16'h0202, 2'd0, 16'h0);
    tick();
    chk("rst2_dly", 32'(bus.ex_in_delay_o), 32'd0);
    chk("rst2_reload", 32'(bus.ex_pc_o), 32'h0202);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
